// File: rtl/elastic_stage.sv
// -----------------------------------------------------------------------------
// elastic_stage
//   Valid/ready pipeline stage register holding up to DEPTH payload words in
//   arrival order. Output is first-word fall-through: the head entry is visible
//   on out_data in the cycle after it is pushed into an empty stage. A
//   synchronous flush discards every held entry. A saturating counter records
//   cycles in which the head is offered but not taken.
//
// Parameters
//   WIDTH    payload width in bits (>= 1)
//   DEPTH    entries held (>= 1), any value, not limited to powers of two
//   STALL_W  width of the saturating stall counter (>= 1)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush         synchronous kill of all held entries
//   in_valid      upstream offers in_data
//   in_ready      stage can accept this cycle (depends on occupancy only)
//   in_data       upstream payload
//   out_valid     head entry presented on out_data
//   out_ready     downstream takes the head this cycle
//   out_data      head payload, forced to zero while out_valid is low
//   count         entries currently held
//   stall_cycles  saturating count of cycles with out_valid && !out_ready
// -----------------------------------------------------------------------------
module elastic_stage #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 2,
    parameter int STALL_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [STALL_W-1:0]         stall_cycles
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [STALL_W-1:0] stall_q,  stall_d;
    logic               push, pop;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // in_ready looks only at occupancy, so a full stage refuses input even in a
    // cycle where the head is being popped; this keeps out_ready off the
    // upstream timing path.
    assign in_ready     = (count_q < FULL_CNT);
    assign out_valid    = (count_q != '0);
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;
    assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count        = count_q;
    assign stall_cycles = stall_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, otherwise a path
        // that skips an assignment infers a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;

        // Stall accounting is independent of flush; only reset clears it.
        if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_W'(1);
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order across processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // NOTE: the payload array has no reset; stale contents are never visible
    // because out_data is masked by out_valid, and omitting the reset lets the
    // array map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_elastic_stage.sv
// -----------------------------------------------------------------------------
// tb_elastic_stage
//   Three stage instances run side by side on one clock:
//     index 0 : DEPTH=1, STALL_W=3   (bubble stage, stall saturation)
//     index 1 : DEPTH=2, STALL_W=16  (streaming, backpressure, reset, flush)
//     index 2 : DEPTH=3, STALL_W=16  (pointer wrap with random out_ready)
//   A per-instance queue holds the words the stage should be holding; it is
//   filled on accepted pushes and drained on pops. Occupancy, handshake
//   outputs, head data and the stall counter are compared every cycle.
// -----------------------------------------------------------------------------
module tb_elastic_stage;

    typedef struct {
        logic        ir;
        logic        ov;
        logic [15:0] od;
        logic [31:0] cnt;
        logic [31:0] st;
    } obs_t;

    logic clk;
    logic rst_n;

    logic        iv   [3];
    logic        ordy [3];
    logic        fl   [3];
    logic [15:0] id   [3];

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [15:0] od0, od1, od2;
    logic [0:0]  cnt0;
    logic [1:0]  cnt1, cnt2;
    logic [2:0]  st0;
    logic [15:0] st1, st2;

    logic [15:0] q0[$], q1[$], q2[$];
    logic [31:0] exp_st [3];

    int vectors     = 0;
    int miscompares = 0;

    elastic_stage #(.WIDTH(16), .DEPTH(1), .STALL_W(3)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir0), .in_data(id[0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0),
        .count(cnt0), .stall_cycles(st0)
    );

    elastic_stage #(.WIDTH(16), .DEPTH(2), .STALL_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir1), .in_data(id[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1),
        .count(cnt1), .stall_cycles(st1)
    );

    elastic_stage #(.WIDTH(16), .DEPTH(3), .STALL_W(16)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(fl[2]),
        .in_valid(iv[2]), .in_ready(ir2), .in_data(id[2]),
        .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2),
        .count(cnt2), .stall_cycles(st2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int depth_of(input int k);
        return k + 1;
    endfunction

    function automatic logic [31:0] stall_max(input int k);
        return (k == 0) ? 32'd7 : 32'd65535;
    endfunction

    function automatic obs_t sample(input int k);
        obs_t o;
        case (k)
            0:       o = '{ir0, ov0, od0, 32'(cnt0), 32'(st0)};
            1:       o = '{ir1, ov1, od1, 32'(cnt1), 32'(st1)};
            default: o = '{ir2, ov2, od2, 32'(cnt2), 32'(st2)};
        endcase
        return o;
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [15:0] qfront(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(input int k, input logic [15:0] d);
        case (k)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic qpop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic qclear_all();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int k = 0; k < 3; k++) exp_st[k] = 32'd0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every instance's state-derived outputs against the model.
    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            obs_t o;
            int   sz;
            o  = sample(k);
            sz = qsize(k);
            check($sformatf("u%0d count", k),     o.cnt,     32'(sz));
            check($sformatf("u%0d in_ready", k),  32'(o.ir), 32'(sz < depth_of(k)));
            check($sformatf("u%0d out_valid", k), 32'(o.ov), 32'(sz != 0));
            if (sz != 0)
                check($sformatf("u%0d head", k),  32'(o.od), 32'(qfront(k)));
            else
                check($sformatf("u%0d idle data", k), 32'(o.od), 32'd0);
            check($sformatf("u%0d stall", k),     o.st,      exp_st[k]);
        end
    endtask

    // One clock cycle: check, drive instance u, advance the model, wait an edge.
    task automatic tick(input int u, input logic v, input logic [15:0] d,
                        input logic r, input logic f);
        check_all();
        iv[u]   = v;
        id[u]   = d;
        ordy[u] = r;
        fl[u]   = f;
        for (int k = 0; k < 3; k++) begin
            int sz;
            sz = qsize(k);
            if (sz != 0 && !ordy[k] && exp_st[k] != stall_max(k))
                exp_st[k] = exp_st[k] + 32'd1;
            if (fl[k]) begin
                case (k)
                    0:       q0.delete();
                    1:       q1.delete();
                    default: q2.delete();
                endcase
            end else begin
                if (sz != 0 && ordy[k]) qpop(k);
                if (iv[k] && sz < depth_of(k)) qpush(k, id[k]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        int budget;

        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0; id[k] = 16'h0;
            exp_st[k] = 32'd0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Streaming through DEPTH=2: one word per cycle, occupancy stays at 1.
        for (int i = 1; i <= 8; i++) tick(1, 1'b1, 16'(i), 1'b1, 1'b0);
        tick(1, 1'b0, 16'h0, 1'b1, 1'b0);
        tick(1, 1'b0, 16'h0, 1'b1, 1'b0);

        // Backpressure: fill with A,B, hold C while full, then drain in order.
        tick(1, 1'b1, 16'h000A, 1'b0, 1'b0);
        tick(1, 1'b1, 16'h000B, 1'b0, 1'b0);
        tick(1, 1'b1, 16'h000C, 1'b0, 1'b0);
        tick(1, 1'b1, 16'h000C, 1'b0, 1'b0);
        tick(1, 1'b1, 16'h000C, 1'b1, 1'b0);   // pop A, C refused while full
        tick(1, 1'b1, 16'h000C, 1'b1, 1'b0);   // pop B, push C
        tick(1, 1'b0, 16'h0000, 1'b1, 1'b0);   // pop C
        tick(1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a stream with two words held.
        tick(1, 1'b1, 16'h00D1, 1'b0, 1'b0);
        tick(1, 1'b1, 16'h00D2, 1'b0, 1'b0);
        check("pre-reset count", 32'(cnt1), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("reset count",     32'(cnt1), 32'd0);
        check("reset out_valid", 32'(ov1),  32'd0);
        check("reset out_data",  32'(od1),  32'd0);
        check("reset in_ready",  32'(ir1),  32'd1);
        check("reset stall",     32'(st1),  32'd0);
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0;
        end
        qclear_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 1'b0, 16'h0, 1'b1, 1'b0);

        // Flush with simultaneous push and pop at count=1: nothing survives.
        tick(1, 1'b1, 16'h0011, 1'b0, 1'b0);
        tick(1, 1'b1, 16'h0022, 1'b1, 1'b1);
        tick(1, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick(1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // DEPTH=3 wrap: ten words through with random out_ready.
        n      = 0;
        budget = 0;
        while ((n < 10 || qsize(2) != 0) && budget < 200) begin
            logic acc;
            acc = (n < 10) && (qsize(2) < 3);
            tick(2, n < 10, 16'(16'h0100 + n), 1'($urandom_range(0, 1)), 1'b0);
            if (acc) n++;
            budget++;
        end
        check("u2 words accepted", 32'(n), 32'd10);
        check("u2 drained", 32'(qsize(2)), 32'd0);
        check("u2 drain within budget", 32'(budget < 200), 32'd1);

        // DEPTH=1 bubble stage: in_ready alternates under continuous offer.
        for (int i = 0; i < 6; i++) tick(0, 1'b1, 16'(16'h0200 + i), 1'b1, 1'b0);
        tick(0, 1'b0, 16'h0, 1'b1, 1'b0);

        // STALL_W=3 counter saturates at 7 while the head is refused.
        tick(0, 1'b1, 16'h0077, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(0, 1'b0, 16'h0, 1'b0, 1'b0);
        check("u0 stall saturated", 32'(st0), 32'd7);
        tick(0, 1'b0, 16'h0, 1'b1, 1'b0);
        tick(0, 1'b0, 16'h0, 1'b1, 1'b0);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
